// File: rtl/hex_scan_display_n.sv
// ============================================================================
// Module      : hex_scan_display_n
// Description : Multiplexed common-anode seven-segment controller with
//               refresh prescaler, snapshot load, decimal points,
//               leading-zero blanking and PWM brightness.
//               Optional lamp test enabled by macro HEX_SCAN_LAMP_TEST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_scan_display_n #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_HZ     = 100000000,
  parameter int SCAN_HZ    = 1000,
  parameter int BRIGHT_W   = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [4*NUM_DIGITS-1:0]       D,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic                          load,
  input  logic                          blank_lz,
  input  logic [BRIGHT_W-1:0]           brightness,
`ifdef HEX_SCAN_LAMP_TEST_EN
  input  logic                          lamp_test,
`endif
  output logic [7:0]                    seg,
  output logic [NUM_DIGITS-1:0]         anodes,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

  localparam int c_div    = CLK_HZ / SCAN_HZ;
  localparam int c_cnt_w  = $clog2(c_div);
  localparam int c_idx_w  = $clog2(NUM_DIGITS);
  localparam int c_div_w  = $clog2(c_div + 1);
  localparam int c_prod_w = BRIGHT_W + 1 + c_div_w;

  logic [c_cnt_w-1:0]      r_presc;
  logic [c_idx_w-1:0]      r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow_d;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic [7:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_anodes;

  logic                    w_tick;
  logic                    w_lamp;
  logic [3:0]              w_nibble [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   w_dp;
  logic [NUM_DIGITS-1:0]   w_zero_prefix;
  logic [BRIGHT_W:0]       w_bright_p1;
  logic [c_prod_w-1:0]     w_prod;
  logic [c_prod_w-1:0]     w_on_raw;
  logic [c_prod_w-1:0]     w_on_window;
  logic                    w_blank;
  logic                    w_lit;
  logic [7:0]              w_seg_next;
  logic [NUM_DIGITS-1:0]   w_anodes_next;

  function automatic logic [6:0] f_hex7(input logic [3:0] nib);
    logic [6:0] s;
    s = 7'b1111111;
    unique case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

`ifdef HEX_SCAN_LAMP_TEST_EN
  assign w_lamp = lamp_test;
`else
  assign w_lamp = 1'b0;
`endif

  assign w_tick = (r_presc == c_cnt_w'(c_div - 1));

  // Re-order the shadow word into left-to-right digit order; the zero prefix
  // marks digits whose own nibble and every nibble to their left are zero.
  generate
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
      assign w_nibble[k] = r_shadow_d[4*(NUM_DIGITS-k)-1 -: 4];
      assign w_dp[k]     = r_shadow_dp[NUM_DIGITS-1-k];
      if (k == 0) begin : g_first
        assign w_zero_prefix[k] = (w_nibble[k] == 4'h0);
      end else begin : g_rest
        assign w_zero_prefix[k] = w_zero_prefix[k-1] & (w_nibble[k] == 4'h0);
      end
    end
  endgenerate

  assign w_bright_p1 = {1'b0, brightness} + {{BRIGHT_W{1'b0}}, 1'b1};
  assign w_prod      = c_prod_w'(w_bright_p1) * c_prod_w'(c_div);
  assign w_on_raw    = w_prod >> BRIGHT_W;
  assign w_on_window = (w_on_raw == '0) ? c_prod_w'(1) : w_on_raw;

  always_comb begin
    w_blank       = blank_lz & w_zero_prefix[r_idx]
                  & (r_idx != c_idx_w'(NUM_DIGITS - 1)) & ~w_lamp;
    w_lit         = (c_prod_w'(r_presc) < w_on_window) & ~w_blank;
    w_anodes_next = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_lit && (NUM_DIGITS - 1 - k == int'(r_idx))) begin
        w_anodes_next[k] = 1'b0;
      end
    end
    if (w_lamp) begin
      w_seg_next = 8'h00;
    end else if (w_blank) begin
      w_seg_next = 8'hFF;
    end else begin
      w_seg_next = {~w_dp[r_idx], f_hex7(w_nibble[r_idx])};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_shadow_d  <= '0;
      r_shadow_dp <= '0;
      r_seg       <= 8'hFF;
      r_anodes    <= '1;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + c_cnt_w'(1);
      if (w_tick) begin
        r_idx <= (r_idx == c_idx_w'(NUM_DIGITS - 1)) ? '0 : r_idx + c_idx_w'(1);
      end
      if (load) begin
        r_shadow_d  <= D;
        r_shadow_dp <= dp_in;
      end
      r_seg    <= w_seg_next;
      r_anodes <= w_anodes_next;
    end
  end

  assign seg       = r_seg;
  assign anodes    = r_anodes;
  assign digit_idx = r_idx;

endmodule

`default_nettype wire

// File: tb/tb_hex_scan_display_n.sv
// ============================================================================
// Module      : tb_hex_scan_display_n
// Description : Randomized self-checking bench for hex_scan_display_n
//               (4-digit and 3-digit instances, DIV = 10).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hex_scan_display_n;

  localparam int N       = 4;
  localparam int N3      = 3;
  localparam int CLK_HZ  = 1000;
  localparam int SCAN_HZ = 100;
  localparam int BW      = 3;
  localparam int DIV     = CLK_HZ / SCAN_HZ;
`ifdef HEX_SCAN_LAMP_TEST_EN
  localparam bit HAS_LAMP = 1'b1;
`else
  localparam bit HAS_LAMP = 1'b0;
`endif

  // Active-low g..a patterns for hex digits 0..F
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] d = '0;
  logic [3:0]  dp = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [2:0]  brightness = 3'd7;
  logic        lamp_test = 1'b0;

  logic [7:0]  seg, seg3;
  logic [3:0]  anodes;
  logic [2:0]  anodes3;
  logic [1:0]  idx, idx3;

  int          t;
  logic [15:0] sh_d;
  logic [3:0]  sh_dp;
  logic [11:0] sh_d3;
  logic [2:0]  sh_dp3;
  int          n_checks = 0;
  int          n_errors = 0;
  int          lit_count = 0;

  always #5 clk = ~clk;

  hex_scan_display_n #(.NUM_DIGITS(N), .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .BRIGHT_W(BW)) u_dut4 (
    .clk        (clk),
    .reset      (reset),
    .D          (d),
    .dp_in      (dp),
    .load       (load),
    .blank_lz   (blank_lz),
    .brightness (brightness),
`ifdef HEX_SCAN_LAMP_TEST_EN
    .lamp_test  (lamp_test),
`endif
    .seg        (seg),
    .anodes     (anodes),
    .digit_idx  (idx)
  );

  hex_scan_display_n #(.NUM_DIGITS(N3), .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .BRIGHT_W(BW)) u_dut3 (
    .clk        (clk),
    .reset      (reset),
    .D          (d[11:0]),
    .dp_in      (dp[2:0]),
    .load       (load),
    .blank_lz   (blank_lz),
    .brightness (brightness),
`ifdef HEX_SCAN_LAMP_TEST_EN
    .lamp_test  (lamp_test),
`endif
    .seg        (seg3),
    .anodes     (anodes3),
    .digit_idx  (idx3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 30)
        $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Expected {seg, anodes} produced by the edge following cycle t of a scan.
  function automatic logic [15:0] model_out(input int n, input int tc, input logic [31:0] sd,
                                            input logic [7:0] sdp, input logic blz,
                                            input int br, input logic lamp);
    int presc, di, on, nib, sh;
    logic blank;
    logic [7:0] s, a;
    presc = tc % DIV;
    di    = (tc / DIV) % n;
    on    = ((br + 1) * DIV) >> BW;
    if (on < 1) on = 1;
    sh    = 4 * (n - 1 - di);
    nib   = int'((sd >> sh) & 32'hF);
    blank = blz && (di != n - 1) && ((sd >> sh) == 32'd0);
    if (lamp) blank = 1'b0;
    a = 8'hFF;
    if (presc < on && !blank) a[n-1-di] = 1'b0;
    if (lamp)       s = 8'h00;
    else if (blank) s = 8'hFF;
    else            s = {~sdp[n-1-di], SEG_TAB[nib]};
    return {s, a};
  endfunction

  task automatic model_reset();
    t = 0; sh_d = '0; sh_dp = '0; sh_d3 = '0; sh_dp3 = '0;
  endtask

  task automatic cycle();
    logic [15:0] e4, e3;
    logic        lm;
    @(posedge clk);
    lm = lamp_test & HAS_LAMP;
    e4 = model_out(N,  t, 32'(sh_d),  8'(sh_dp),  blank_lz, int'(brightness), lm);
    e3 = model_out(N3, t, 32'(sh_d3), 8'(sh_dp3), blank_lz, int'(brightness), lm);
    if (load) begin
      sh_d = d; sh_dp = dp; sh_d3 = d[11:0]; sh_dp3 = dp[2:0];
    end
    t++;
    #1;
    check("seg",        32'(seg),     32'(e4[15:8]));
    check("anodes",     32'(anodes),  32'(e4[3:0]));
    check("digit_idx",  32'(idx),     32'((t / DIV) % N));
    check("seg3",       32'(seg3),    32'(e3[15:8]));
    check("anodes3",    32'(anodes3), 32'(e3[2:0]));
    check("digit_idx3", 32'(idx3),    32'((t / DIV) % N3));
    if (anodes != 4'hF) lit_count++;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_seg"},    32'(seg),     32'h FF);
    check({tag, "_anodes"}, 32'(anodes),  32'h F);
    check({tag, "_idx"},    32'(idx),     32'd0);
    check({tag, "_seg3"},   32'(seg3),    32'h FF);
    check({tag, "_an3"},    32'(anodes3), 32'h7);
    check({tag, "_idx3"},   32'(idx3),    32'd0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic duty(input string tag, input logic [2:0] br, input int lit_per_digit);
    brightness = br;
    lit_count  = 0;
    run(4 * DIV);
    check(tag, 32'(lit_count), 32'(4 * lit_per_digit));
  endtask

  initial begin
    int guard;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    #2 reset = 1'b0;

    // Scan and decode 12AF with dp on digit 1
    d = 16'h12AF; dp = 4'b0100; load = 1'b1; brightness = 3'd7;
    cycle();
    load = 1'b0;
    run(45);

    duty("duty_b7", 3'd7, 10);
    duty("duty_b3", 3'd3, 5);
    duty("duty_b0", 3'd0, 1);
    brightness = 3'd7;

    // Leading-zero blanking
    blank_lz = 1'b1; d = 16'h0030; dp = 4'b1111; load = 1'b1;
    cycle();
    load = 1'b0;
    run(45);
    d = 16'h0000; load = 1'b1;
    cycle();
    load = 1'b0;
    run(45);
    blank_lz = 1'b0;

    // Snapshot holds until the next load
    d = 16'h1111; dp = 4'b0000; load = 1'b1;
    cycle();
    load = 1'b0; d = 16'h2222;
    run(45);
    load = 1'b1;
    cycle();
    load = 1'b0;
    run(25);

    // Reset in the middle of digit 2
    guard = 0;
    while (!(((t / DIV) % N) == 2 && (t % DIV) == 4) && guard < 100) begin
      cycle();
      guard++;
    end
    check("wait_digit2", 32'(guard < 100), 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_vals("mid_rst");
    @(posedge clk);
    #1 check_reset_vals("hold_rst");
    #2 reset = 1'b0;
    model_reset();
    run(DIV - 1);
    check("idx_before_tick", 32'(idx), 32'd0);
    cycle();
    check("idx_after_tick", 32'(idx), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      int z;
      z    = int'($urandom % 5);
      d    = 16'($urandom & (32'hFFFF >> (4 * z)));
      dp   = 4'($urandom);
      load = ($urandom % 6 == 0);
      if ($urandom % 40 == 0) blank_lz   = ~blank_lz;
      if ($urandom % 30 == 0) brightness = 3'($urandom);
      if ($urandom % 60 == 0) lamp_test  = ~lamp_test;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
